// File: rtl/onchip_ram_arbiter_if.sv
// Bus bundle between two Avalon-MM masters, the shared on-chip RAM and the clear control.
interface onchip_ram_arbiter_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BE_W   = 4
);
  logic [ADDR_W-1:0] m0_address;
  logic              m0_read;
  logic              m0_write;
  logic [BE_W-1:0]   m0_byteenable;
  logic [DATA_W-1:0] m0_writedata;
  logic              m0_waitrequest;
  logic [DATA_W-1:0] m0_readdata;
  logic              m0_readdatavalid;

  logic [ADDR_W-1:0] m1_address;
  logic              m1_read;
  logic              m1_write;
  logic [BE_W-1:0]   m1_byteenable;
  logic [DATA_W-1:0] m1_writedata;
  logic              m1_waitrequest;
  logic [DATA_W-1:0] m1_readdata;
  logic              m1_readdatavalid;

  logic [ADDR_W-1:0] ram_address;
  logic [BE_W-1:0]   ram_byteenable;
  logic              ram_chipselect;
  logic              ram_write;
  logic [DATA_W-1:0] ram_writedata;
  logic              ram_clken;
  logic [DATA_W-1:0] ram_readdata;

  logic              clear_start;
  logic              clear_busy;
  logic              clear_done;

  modport slave (
    input  m0_address, m0_read, m0_write, m0_byteenable, m0_writedata,
    output m0_waitrequest, m0_readdata, m0_readdatavalid,
    input  m1_address, m1_read, m1_write, m1_byteenable, m1_writedata,
    output m1_waitrequest, m1_readdata, m1_readdatavalid,
    output ram_address, ram_byteenable, ram_chipselect, ram_write, ram_writedata, ram_clken,
    input  ram_readdata,
    input  clear_start,
    output clear_busy, clear_done
  );

  modport master (
    output m0_address, m0_read, m0_write, m0_byteenable, m0_writedata,
    input  m0_waitrequest, m0_readdata, m0_readdatavalid,
    output m1_address, m1_read, m1_write, m1_byteenable, m1_writedata,
    input  m1_waitrequest, m1_readdata, m1_readdatavalid,
    input  ram_address, ram_byteenable, ram_chipselect, ram_write, ram_writedata, ram_clken,
    output ram_readdata,
    output clear_start,
    input  clear_busy, clear_done
  );
endinterface

// File: rtl/onchip_ram_arbiter.sv
// Round-robin arbiter sharing a single-port RAM between two Avalon-MM masters,
// with a zero-fill sequencer that holds both masters off while it clears the RAM.
module onchip_ram_arbiter #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BE_W   = 4,
  parameter int unsigned DEPTH  = 4096
) (
  input logic                 clk,
  input logic                 reset_n,
  onchip_ram_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH);

  typedef enum logic {ST_ARB, ST_CLEAR} state_e;

  state_e             state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic               rd_pending_q, rd_pending_d;
  logic               rd_owner_q, rd_owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               req0, req1, gnt0, gnt1;
  logic               wait0, wait1;
  logic               cs, wr, busy, done;
  logic [ADDR_W-1:0]  addr;
  logic [BE_W-1:0]    be;
  logic [DATA_W-1:0]  wdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_ARB;
      last_grant_q <= 1'b1;
      rd_pending_q <= 1'b0;
      rd_owner_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rd_pending_q <= rd_pending_d;
      rd_owner_q   <= rd_owner_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rd_pending_d = 1'b0;
    rd_owner_d   = rd_owner_q;
    cnt_d        = cnt_q;
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    wait0        = 1'b0;
    wait1        = 1'b0;
    cs           = 1'b0;
    wr           = 1'b0;
    addr         = '0;
    be           = '0;
    wdata        = '0;
    busy         = 1'b0;
    done         = 1'b0;
    req0         = bus.m0_read | bus.m0_write;
    req1         = bus.m1_read | bus.m1_write;

    case (state_q)
      ST_ARB: begin
        // On a tie the master that did not win last time is served.
        gnt0  = req0 & (~req1 | last_grant_q);
        gnt1  = req1 & (~req0 | ~last_grant_q);
        wait0 = req0 & ~gnt0;
        wait1 = req1 & ~gnt1;
        if (gnt0) begin
          cs    = 1'b1;
          wr    = bus.m0_write;
          addr  = bus.m0_address;
          be    = bus.m0_byteenable;
          wdata = bus.m0_writedata;
        end else if (gnt1) begin
          cs    = 1'b1;
          wr    = bus.m1_write;
          addr  = bus.m1_address;
          be    = bus.m1_byteenable;
          wdata = bus.m1_writedata;
        end
        if (gnt0 | gnt1) begin
          last_grant_d = gnt1;
          rd_owner_d   = gnt1;
          rd_pending_d = ~wr;
        end
        if (bus.clear_start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        busy  = 1'b1;
        wait0 = req0;
        wait1 = req1;
        cs    = 1'b1;
        wr    = 1'b1;
        addr  = ADDR_W'(cnt_q);
        be    = '1;
        if (cnt_q == CNT_W'(DEPTH - 1)) begin
          done    = 1'b1;
          state_d = ST_ARB;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  // While reset is held the masters are stalled and the RAM is quiet.
  assign bus.m0_waitrequest   = ~reset_n | wait0;
  assign bus.m1_waitrequest   = ~reset_n | wait1;
  assign bus.m0_readdata      = reset_n ? bus.ram_readdata : '0;
  assign bus.m1_readdata      = reset_n ? bus.ram_readdata : '0;
  assign bus.m0_readdatavalid = reset_n & rd_pending_q & ~rd_owner_q;
  assign bus.m1_readdatavalid = reset_n & rd_pending_q & rd_owner_q;

  assign bus.ram_address      = reset_n ? addr  : '0;
  assign bus.ram_byteenable   = reset_n ? be    : '0;
  assign bus.ram_writedata    = reset_n ? wdata : '0;
  assign bus.ram_chipselect   = reset_n & cs;
  assign bus.ram_write        = reset_n & wr;
  assign bus.ram_clken        = reset_n;

  assign bus.clear_busy       = reset_n & busy;
  assign bus.clear_done       = reset_n & done;

endmodule

// File: tb/tb_onchip_ram_arbiter.sv
// Scoreboard bench for onchip_ram_arbiter: directed traffic, read data checked by a monitor.
module tb_onchip_ram_arbiter;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  onchip_ram_arbiter_if #(.ADDR_W(12), .DATA_W(32), .BE_W(4)) bus ();

  onchip_ram_arbiter #(.ADDR_W(12), .DATA_W(32), .BE_W(4), .DEPTH(4096)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp0_q[$];
  logic [31:0] exp1_q[$];
  logic [31:0] mem [0:4095];

  // RAM model: byte-enabled writes, registered read data.
  always @(posedge clk) begin
    if (bus.ram_clken && bus.ram_chipselect) begin
      if (bus.ram_write) begin
        for (int b = 0; b < 4; b++)
          if (bus.ram_byteenable[b]) mem[bus.ram_address][8*b +: 8] <= bus.ram_writedata[8*b +: 8];
      end else begin
        bus.ram_readdata <= mem[bus.ram_address];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Read-return monitor.
  always @(negedge clk) begin
    if (bus.m0_readdatavalid) begin
      if (exp0_q.size() == 0) check("m0_rdv_unexpected", 32'd1, 32'd0);
      else check("m0_rdata", bus.m0_readdata, exp0_q.pop_front());
    end
    if (bus.m1_readdatavalid) begin
      if (exp1_q.size() == 0) check("m1_rdv_unexpected", 32'd1, 32'd0);
      else check("m1_rdata", bus.m1_readdata, exp1_q.pop_front());
    end
  end

  task automatic clear_reqs();
    bus.m0_read = 1'b0; bus.m0_write = 1'b0;
    bus.m1_read = 1'b0; bus.m1_write = 1'b0;
  endtask

  task automatic idle_bus();
    @(posedge clk); #1;
    clear_reqs();
  endtask

  // Single-cycle transfer by one master, expected to be granted immediately.
  task automatic xfer(input bit m, input bit wr, input logic [11:0] a, input logic [3:0] be,
                      input logic [31:0] d, input logic [31:0] exp);
    @(posedge clk); #1;
    clear_reqs();
    if (!m) begin
      bus.m0_address = a; bus.m0_byteenable = be; bus.m0_writedata = d;
      bus.m0_write = wr; bus.m0_read = ~wr;
      if (!wr) exp0_q.push_back(exp);
    end else begin
      bus.m1_address = a; bus.m1_byteenable = be; bus.m1_writedata = d;
      bus.m1_write = wr; bus.m1_read = ~wr;
      if (!wr) exp1_q.push_back(exp);
    end
    @(negedge clk);
    check(m ? "m1_wait_xfer" : "m0_wait_xfer", 32'(m ? bus.m1_waitrequest : bus.m0_waitrequest), 32'd0);
    check("ram_addr_xfer", 32'(bus.ram_address), 32'(a));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nbusy, wr_err, done_cnt, done_ok;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h5A00_0000 | 32'(i);
    bus.ram_readdata = '0;
    bus.clear_start = 1'b0;
    bus.m0_address = '0; bus.m0_byteenable = '0; bus.m0_writedata = '0;
    bus.m1_address = '0; bus.m1_byteenable = '0; bus.m1_writedata = '0;
    clear_reqs();
    reset_n = 1'b0;
    bus.m0_read = 1'b1;
    #3;
    check("rst_m0_wait", 32'(bus.m0_waitrequest), 32'd1);
    check("rst_m1_wait", 32'(bus.m1_waitrequest), 32'd1);
    check("rst_clken", 32'(bus.ram_clken), 32'd0);
    check("rst_cs", 32'(bus.ram_chipselect), 32'd0);
    check("rst_busy", 32'(bus.clear_busy), 32'd0);
    repeat (2) @(posedge clk);
    #1; reset_n = 1'b1; clear_reqs();
    @(negedge clk);
    check("idle_clken", 32'(bus.ram_clken), 32'd1);
    check("idle_m0_wait", 32'(bus.m0_waitrequest), 32'd0);

    // Write then read back by m0.
    xfer(0, 1, 12'h010, 4'hF, 32'hDEAD_BEEF, 32'h0);
    xfer(0, 0, 12'h010, 4'hF, 32'h0, 32'hDEAD_BEEF);
    xfer(0, 1, 12'h001, 4'hF, 32'hA0A0_0001, 32'h0);
    xfer(0, 1, 12'h002, 4'hF, 32'hB0B0_0002, 32'h0);
    xfer(0, 1, 12'h020, 4'hF, 32'h1122_3344, 32'h0);
    // Byte-lane write by m1, then merged readback.
    xfer(1, 1, 12'h020, 4'b0010, 32'h0000_AB00, 32'h0);
    xfer(1, 0, 12'h020, 4'hF, 32'h0, 32'h1122_AB44);
    idle_bus();

    // Both masters read continuously; m1 was served last so m0 goes first.
    @(posedge clk); #1;
    bus.m0_address = 12'h001; bus.m0_read = 1'b1;
    bus.m1_address = 12'h002; bus.m1_read = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) exp0_q.push_back(32'hA0A0_0001);
      else            exp1_q.push_back(32'hB0B0_0002);
      @(negedge clk);
      check("rr_m0_wait", 32'(bus.m0_waitrequest), 32'(i % 2));
      check("rr_m1_wait", 32'(bus.m1_waitrequest), 32'((i + 1) % 2));
      check("rr_addr", 32'(bus.ram_address), (i % 2 == 0) ? 32'h001 : 32'h002);
      @(posedge clk); #1;
    end
    clear_reqs();

    // Zero-fill with m0 read held; the read in the start cycle still returns.
    @(posedge clk); #1;
    bus.clear_start = 1'b1;
    bus.m0_address = 12'h7FF; bus.m0_read = 1'b1;
    exp0_q.push_back(32'h5A00_07FF);
    @(negedge clk);
    check("clr_start_m0_wait", 32'(bus.m0_waitrequest), 32'd0);
    @(posedge clk); #1;
    bus.clear_start = 1'b0;
    nbusy = 0; wr_err = 0; done_cnt = 0; done_ok = 0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (!bus.clear_busy) break;
      nbusy++;
      if (!bus.m0_waitrequest) wr_err++;
      if (bus.clear_done) begin
        done_cnt++;
        if (bus.ram_address == 12'hFFF && nbusy == 4096) done_ok = 1;
      end
      if (c == 10) bus.clear_start = 1'b1;
      if (c == 11) bus.clear_start = 1'b0;
    end
    check("clr_busy_cycles", 32'(nbusy), 32'd4096);
    check("clr_wait_held", 32'(wr_err), 32'd0);
    check("clr_done_count", 32'(done_cnt), 32'd1);
    check("clr_done_at_fff", 32'(done_ok), 32'd1);
    check("post_clr_m0_wait", 32'(bus.m0_waitrequest), 32'd0);
    check("post_clr_addr", 32'(bus.ram_address), 32'h7FF);
    exp0_q.push_back(32'h0);
    @(posedge clk); #1;
    bus.m0_address = 12'h000; exp0_q.push_back(32'h0);
    @(negedge clk);
    check("post_clr_rd0_wait", 32'(bus.m0_waitrequest), 32'd0);
    @(posedge clk); #1;
    bus.m0_address = 12'hFFF; exp0_q.push_back(32'h0);
    @(negedge clk);
    check("post_clr_rdfff_wait", 32'(bus.m0_waitrequest), 32'd0);
    idle_bus();

    // Values outside the partially cleared range, for after the reset below.
    xfer(0, 1, 12'h800, 4'hF, 32'h1234_5678, 32'h0);
    xfer(1, 1, 12'h801, 4'hF, 32'h8765_4321, 32'h0);
    idle_bus();

    // Reset in the middle of a clear.
    @(posedge clk); #1;
    bus.clear_start = 1'b1;
    @(posedge clk); #1;
    bus.clear_start = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (bus.clear_done) done_cnt++;
      if (bus.ram_address == 12'd100) break;
    end
    check("mid_clr_addr", 32'(bus.ram_address), 32'd100);
    check("mid_clr_busy", 32'(bus.clear_busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(bus.clear_busy), 32'd0);
    check("mid_rst_done", 32'(bus.clear_done), 32'd0);
    check("mid_rst_m0_wait", 32'(bus.m0_waitrequest), 32'd1);
    check("mid_rst_clken", 32'(bus.ram_clken), 32'd0);
    repeat (3) begin
      @(negedge clk);
      if (bus.clear_done) done_cnt++;
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    bus.m0_address = 12'h800; bus.m0_read = 1'b1;
    bus.m1_address = 12'h801; bus.m1_read = 1'b1;
    exp0_q.push_back(32'h1234_5678);
    @(negedge clk);
    if (bus.clear_done) done_cnt++;
    check("rst_tie_m0_wait", 32'(bus.m0_waitrequest), 32'd0);
    check("rst_tie_m1_wait", 32'(bus.m1_waitrequest), 32'd1);
    check("rst_tie_busy", 32'(bus.clear_busy), 32'd0);
    @(posedge clk); #1;
    bus.m0_read = 1'b0;
    exp1_q.push_back(32'h8765_4321);
    @(negedge clk);
    check("rst_tie2_m1_wait", 32'(bus.m1_waitrequest), 32'd0);
    idle_bus();
    repeat (4) begin
      @(negedge clk);
      if (bus.clear_done) done_cnt++;
    end
    check("mid_rst_no_done", 32'(done_cnt), 32'd0);
    check("idle_cs", 32'(bus.ram_chipselect), 32'd0);
    check("idle_addr", 32'(bus.ram_address), 32'd0);
    check("sb0_drained", 32'(exp0_q.size()), 32'd0);
    check("sb1_drained", 32'(exp1_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/onchip_ram_arbiter.md
Name: onchip_ram_arbiter

Overview:
- Shares the single-port 4096x32 on-chip RAM (byte-enabled, 1-cycle read latency) between two Avalon-MM masters: m0 (CPU data port) and m1 (alarm tone/display fetch engine).
- Arbitration is round-robin with waitrequest back-pressure and readdatavalid return routing.
- Contains a zero-fill sequencer that clears the whole RAM on command while holding off both masters.

Parameters:
ADDR_W, 12, word address width
DATA_W, 32, data width
BE_W, 4, byteenable width (DATA_W/8)
DEPTH, 4096, words cleared by the zero-fill sequencer

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
m0_address  in  ADDR_W  master 0 word address
m0_read  in  1  master 0 read request
m0_write  in  1  master 0 write request
m0_byteenable  in  BE_W  master 0 byte lanes
m0_writedata  in  DATA_W  master 0 write data
m0_waitrequest  out  1  master 0 stall
m0_readdata  out  DATA_W  master 0 read data
m0_readdatavalid  out  1  master 0 read data strobe
m1_*  same set and widths as m0_*, for master 1
ram_address  out  ADDR_W  to RAM address
ram_byteenable  out  BE_W  to RAM byteenable
ram_chipselect  out  1  to RAM chipselect
ram_write  out  1  to RAM write
ram_writedata  out  DATA_W  to RAM writedata
ram_clken  out  1  to RAM clken, tied high while reset_n=1
ram_readdata  in  DATA_W  from RAM, valid 1 cycle after a read is issued
clear_start  in  1  1-cycle pulse: begin zero-fill
clear_busy  out  1  high while zero-fill runs
clear_done  out  1  1-cycle pulse on the final clear write

Behaviour:
- Reset (async assert, sync release): state=ARB, last_grant=1 (m0 wins the first tie), rd_pending=0, clear counter=0. All outputs 0 except m0/m1_waitrequest=1 while reset_n=0 and ram_clken=0 while reset_n=0.
- States: ARB, CLEAR.
- ARB:
  - req0 = m0_read|m0_write; req1 = m1_read|m1_write.
  - One request only: that master is granted.
  - Both request: grant goes to the master not equal to last_grant.
  - Grant is combinational. mN_waitrequest = reqN & ~grantN; with no request, waitrequest=0.
  - The granted master's signals are muxed onto ram_*. ram_chipselect=1; ram_write=granted write.
  - last_grant updates on every grant cycle.
  - Read and write asserted together by one master: the request is treated as a write.
- Read return:
  - A granted read sets rd_pending=1 and rd_owner=grantee, registered.
  - Next cycle: ram_readdata drives both mN_readdata buses; mN_readdatavalid=1 only for rd_owner.
  - Back-to-back reads issue every cycle, one per cycle, at full throughput, either master.
- Write latency: 0. A write completes in its grant cycle.
- Idle RAM outputs: chipselect=0, write=0, address/byteenable/writedata=0.
- CLEAR entry:
  - clear_start in ARB enters CLEAR on the next edge.
  - A read granted in the same cycle as clear_start still completes and still returns readdatavalid.
- CLEAR operation:
  - One write per cycle: address=counter, byteenable all ones, writedata=0.
  - Counter runs 0..DEPTH-1. clear_busy=1 throughout.
  - Both waitrequests=1 whenever the corresponding request is asserted.
- CLEAR exit:
  - On the counter=DEPTH-1 write, clear_done pulses.
  - The next state is ARB with counter reset to 0.
  - last_grant is unchanged across CLEAR.
- clear_start while in CLEAR: ignored, no restart.
- reset_n low mid-clear: immediate return to ARB, clear_busy=0, no clear_done. RAM contents are partially cleared, which is acceptable.
- reset_n low with rd_pending: the pending readdatavalid is dropped.

Test Plan:
1. m0 writes 0xDEADBEEF to addr 0x010 (be=4'hF), then reads addr 0x010 -> waitrequest=0 both cycles; m0_readdatavalid=1 one cycle after the read with m0_readdata=0xDEADBEEF; m1_readdatavalid stays 0.
2. m0 and m1 read continuously for 6 cycles from addr 0x001 and 0x002 -> grants alternate m0,m1,m0,m1,m0,m1; each master sees waitrequest=1 on alternate cycles; readdatavalid is routed to the correct master one cycle later.
3. m1 byte write be=4'b0010, data 0x0000AB00 to an addr holding 0x11223344 -> a subsequent read returns 0x1122AB44.
4. Pulse clear_start with m0_read held -> clear_busy=1 for exactly 4096 cycles; m0_waitrequest=1 throughout; clear_done pulses on the cycle ram_address=0xFFF; m0 is granted the cycle after; reads of 0x000, 0x7FF and 0xFFF return 0.
5. Assert reset_n=0 at clear counter 100 -> clear_busy drops asynchronously; clear_done never pulses; after release, m0 wins the first simultaneous request.
6. m0 issues a read in the same cycle as clear_start -> m0_readdatavalid=1 on the next cycle (CLEAR entry cycle) with the correct data.
